seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits from a multiplexed, active-low
// 4-digit 7-segment bus by waiting for STABLE_CYCLES identical {an,display}
// samples before capturing the addressed digit.
// Optional feature: define SEG_ERRCNT_EN to build the saturating illegal-capture
// counter behind err_count. Without it err_count is tied to zero.
// Handshake: none. Inputs are plain level samples taken on every rising edge.
// All outputs are registered. frame_valid is a single-cycle pulse.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  display,
  input  logic [3:0]  an,
  output logic [15:0] hex_out,
  output logic [3:0]  digit_ok,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HELD = 2'd2} state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [10:0] prev_q, prev_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] hex_q, hex_d;
  logic [3:0]  ok_q, ok_d;
  logic [3:0]  err_q, err_d;
  logic        frame_q, frame_d;

  logic        sel_ok;
  logic [1:0]  sel_idx;
  logic        glyph_legal;
  logic        glyph_blank;
  logic [3:0]  glyph_val;
  logic        capture;
  logic        illegal_cap;
  logic [3:0]  mask_set;

  // Selection: exactly one active-low digit strobe identifies the digit.
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (an)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  // Glyph decode of the active-low segment pattern.
  always_comb begin
    glyph_legal = 1'b1;
    glyph_blank = 1'b0;
    glyph_val   = 4'h0;
    case (display)
      7'h40: glyph_val = 4'h0;
      7'h79: glyph_val = 4'h1;
      7'h24: glyph_val = 4'h2;
      7'h30: glyph_val = 4'h3;
      7'h19: glyph_val = 4'h4;
      7'h12: glyph_val = 4'h5;
      7'h02: glyph_val = 4'h6;
      7'h78: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h18: glyph_val = 4'h9;
      7'h08: glyph_val = 4'hA;
      7'h03: glyph_val = 4'hB;
      7'h46: glyph_val = 4'hC;
      7'h21: glyph_val = 4'hD;
      7'h06: glyph_val = 4'hE;
      7'h0E: glyph_val = 4'hF;
      7'h7F: begin
        glyph_legal = 1'b0;
        glyph_blank = 1'b1;
      end
      default: glyph_legal = 1'b0;
    endcase
  end

  // Stability tracker: a change of the sample always restarts the run, and
  // the capture fires exactly once, on the STABLE_CYCLES-th identical sample.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prev_d  = {an, display};
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          state_d = TRACK;
          count_d = 8'd1;
        end
      end
      TRACK, HELD: begin
        if ({an, display} == prev_q) begin
          if (state_q == TRACK) begin
            count_d = count_q + 8'd1;
            if (count_q + 8'd1 == STABLE_C) begin
              capture = 1'b1;
              state_d = HELD;
            end
          end
        end else if (sel_ok) begin
          state_d = TRACK;
          count_d = 8'd1;
        end else begin
          state_d = IDLE;
          count_d = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  // Capture effects on the per-digit outputs and the frame mask. The mask
  // sits at all-ones for one cycle; the following edge pulses frame_valid
  // and starts a fresh mask.
  always_comb begin
    hex_d       = hex_q;
    ok_d        = ok_q;
    err_d       = err_q;
    illegal_cap = 1'b0;
    mask_set    = 4'b0000;
    if (capture) begin
      if (glyph_legal) begin
        hex_d[{sel_idx, 2'b00} +: 4] = glyph_val;
        ok_d[sel_idx]  = 1'b1;
        err_d[sel_idx] = 1'b0;
        mask_set       = 4'b0001 << sel_idx;
      end else if (glyph_blank) begin
        ok_d[sel_idx]  = 1'b0;
        mask_set       = 4'b0001 << sel_idx;
      end else begin
        ok_d[sel_idx]  = 1'b0;
        err_d[sel_idx] = 1'b1;
        illegal_cap    = 1'b1;
      end
    end
    frame_d = (mask_q == 4'hF);
    mask_d  = ((mask_q == 4'hF) ? 4'h0 : mask_q) | mask_set;
  end

  // Single register bank for the FSM and every output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      prev_q  <= 11'd0;
      mask_q  <= 4'd0;
      hex_q   <= 16'd0;
      ok_q    <= 4'd0;
      err_q   <= 4'd0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      hex_q   <= hex_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

`ifdef SEG_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of illegal captures.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (illegal_cap && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  assign hex_out     = hex_q;
  assign digit_ok    = ok_q;
  assign digit_err   = err_q;
  assign frame_valid = frame_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table of directed vectors, hand-written
// corner sequences, and randomized traffic checked cycle by cycle against a
// run-length reference model.
module tb_seg_scan_decoder;

  localparam int STABLE_CYCLES = 4;
`ifdef SEG_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  display = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] hex_out;
  logic [3:0]  digit_ok;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clock       (clock),
    .reset       (reset),
    .display     (display),
    .an          (an),
    .hex_out     (hex_out),
    .digit_ok    (digit_ok),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .err_count   (err_count),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [6:0]  seg_tab [16];
  logic [15:0] m_hex;
  logic [3:0]  m_ok, m_err, seen;
  logic        m_fv, pend;
  logic [7:0]  m_cnt;
  logic [10:0] last;
  int          run;
  int          n_frames;
  logic [31:0] exp_q[$];

  function automatic int glyph(input logic [6:0] d);
    if (d == 7'h7F) return 16;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == d) return k;
    return -1;
  endfunction

  function automatic int sel_index(input logic [3:0] a);
    int zeros = 0;
    int pos = -1;
    for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; pos = k; end
    return (zeros == 1) ? pos : -1;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] a, input logic [6:0] d);
    int si, g;
    logic [10:0] s;
    if (r) begin
      m_hex = '0; m_ok = '0; m_err = '0; m_fv = 1'b0; m_cnt = '0;
      seen = '0; pend = 1'b0; run = 0;
      return;
    end
    s  = {a, d};
    si = sel_index(a);
    if (run > 0 && s == last) run++;
    else run = (si >= 0) ? 1 : 0;
    last = s;
    m_fv = pend;
    pend = 1'b0;
    if (run == STABLE_CYCLES) begin
      g = glyph(d);
      if (g >= 0 && g < 16) begin
        m_hex[si*4 +: 4] = 4'(g);
        m_ok[si] = 1'b1; m_err[si] = 1'b0; seen[si] = 1'b1;
      end else if (g == 16) begin
        m_ok[si] = 1'b0; seen[si] = 1'b1;
      end else begin
        m_ok[si] = 1'b0; m_err[si] = 1'b1;
        if (ERRCNT_ON && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
    end
    if (seen == 4'hF) begin pend = 1'b1; seen = '0; end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] d);
    logic [31:0] got, exp;
    reset = r; an = a; display = d;
    @(posedge clock);
    model_update(r, a, d);
    exp_q.push_back({m_hex, m_ok, m_err, m_fv, m_cnt[6:0]});
    #1;
    if (frame_valid) n_frames++;
    got = {hex_out, digit_ok, digit_err, frame_valid, err_count[6:0]};
    exp = exp_q.pop_front();
    chk("model", got, exp);
    if (err_count[7] !== m_cnt[7]) begin
      checks++; errors++;
      $display("FAIL model_cnt_msb: got %0d expected %0d", err_count, m_cnt);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] d, input int n);
    for (int k = 0; k < n; k++) step(1'b0, a, d);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  disp;
    int          reps;
    logic [15:0] hex;
    logic [3:0]  ok;
    logic [3:0]  err;
    logic        fv;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int f0;
    logic [3:0] ra;
    logic [6:0] rd;
    int r, h;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_hex = '0; m_ok = '0; m_err = '0; m_fv = 1'b0; m_cnt = '0;
    seen = '0; pend = 1'b0; run = 0; last = '0; n_frames = 0;

    // single digit hold, one capture only; then a full scan -> FA10 frame
    tbl = '{
      '{1'b1, 4'hF, 7'h7F, 2,  16'h0000, 4'h0, 4'h0, 1'b0},
      '{1'b0, 4'hE, 7'h30, 3,  16'h0000, 4'h0, 4'h0, 1'b0},
      '{1'b0, 4'hE, 7'h30, 1,  16'h0003, 4'h1, 4'h0, 1'b0},
      '{1'b0, 4'hE, 7'h30, 10, 16'h0003, 4'h1, 4'h0, 1'b0},
      '{1'b0, 4'hE, 7'h40, 4,  16'h0000, 4'h1, 4'h0, 1'b0},
      '{1'b0, 4'hD, 7'h79, 4,  16'h0010, 4'h3, 4'h0, 1'b0},
      '{1'b0, 4'hB, 7'h08, 4,  16'h0A10, 4'h7, 4'h0, 1'b0},
      '{1'b0, 4'h7, 7'h0E, 3,  16'h0A10, 4'h7, 4'h0, 1'b0},
      '{1'b0, 4'h7, 7'h0E, 1,  16'hFA10, 4'hF, 4'h0, 1'b0},
      '{1'b0, 4'h7, 7'h0E, 1,  16'hFA10, 4'hF, 4'h0, 1'b1},
      '{1'b0, 4'h7, 7'h0E, 1,  16'hFA10, 4'hF, 4'h0, 1'b0}
    };

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) step(tbl[i].rst, tbl[i].an, tbl[i].disp);
      chk($sformatf("tbl%0d_hex", i), 32'(hex_out), 32'(tbl[i].hex));
      chk($sformatf("tbl%0d_ok", i), 32'(digit_ok), 32'(tbl[i].ok));
      chk($sformatf("tbl%0d_err", i), 32'(digit_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_fv", i), 32'(frame_valid), 32'(tbl[i].fv));
      if (i == 0) chk("reset_errcnt", 32'(err_count), 32'd0);
    end

    // interrupted run of 2 does not capture; 4 samples of 5 do
    step(1'b1, 4'hF, 7'h7F);
    f0 = n_frames;
    hold(4'hD, 7'h24, 3);
    chk("no_cap_2_ok", 32'(digit_ok), 32'h0);
    hold(4'hD, 7'h12, 3);
    chk("pre5_hex", 32'(hex_out), 32'h0);
    hold(4'hD, 7'h12, 1);
    chk("cap5_hex", 32'(hex_out[7:4]), 32'h5);
    chk("cap5_ok", 32'(digit_ok), 32'h2);

    // illegal pattern on digit 2
    hold(4'hB, 7'h55, 4);
    chk("ill_err", 32'(digit_err), 32'h4);
    chk("ill_ok", 32'(digit_ok), 32'h2);
    chk("ill_hex", 32'(hex_out), 32'h0050);
    chk("ill_cnt", 32'(err_count), ERRCNT_ON ? 32'd1 : 32'd0);
    chk("ill_nofv", 32'(n_frames - f0), 32'd0);

    // two strobes low: never a capture
    hold(4'hC, 7'h30, 8);
    chk("multi_hex", 32'(hex_out), 32'h0050);
    chk("multi_ok", 32'(digit_ok), 32'h2);

    // reset in the middle of a run restarts counting
    hold(4'hE, 7'h79, 2);
    step(1'b1, 4'hE, 7'h79);
    chk("mid_rst_all", {hex_out, digit_ok, digit_err, err_count}, 32'h0);
    hold(4'hE, 7'h79, 3);
    chk("post_rst3_ok", 32'(digit_ok), 32'h0);
    hold(4'hE, 7'h79, 1);
    chk("post_rst4_hex", 32'(hex_out), 32'h0001);
    chk("post_rst4_ok", 32'(digit_ok), 32'h1);

    // blank clears ok but keeps hex value
    hold(4'hE, 7'h7F, 4);
    chk("blank_ok", 32'(digit_ok), 32'h0);
    chk("blank_hex", 32'(hex_out), 32'h0001);

    // saturation of the illegal counter
    for (int k = 0; k < 260; k++) hold(4'hE, (k % 2 == 0) ? 7'h55 : 7'h2A, 4);
    chk("sat_cnt", 32'(err_count), ERRCNT_ON ? 32'd255 : 32'd0);

    // randomized traffic against the model
    for (int s = 0; s < 2500; s++) begin
      r = $urandom_range(0, 99);
      if (r < 85) ra = ~(4'b0001 << $urandom_range(0, 3));
      else ra = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 70) rd = seg_tab[$urandom_range(0, 15)];
      else if (r < 80) rd = 7'h7F;
      else rd = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 199) == 0) step(1'b1, ra, rd);
      h = $urandom_range(1, 7);
      hold(ra, rd, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
